// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// Records each prediction issued by the two-bit predictor in an in-order
// circular queue, matches the oldest one against the actual outcome when a
// branch resolves, and drives the predictor's training inputs
// (taken/transition). It also flags and counts mispredictions.
//
// Optional feature: define MISPREDICT_FLUSH_EN to discard all younger
// entries (including a same-cycle push) on a mispredicting resolve.
//
// Handshake semantics: there is no ready signal. pred_valid is a push
// request, accepted when the queue is not full or when a pop happens in the
// same cycle. resolve_valid is a pop request, accepted when the queue is not
// empty. A rejected request changes no queue state and sets the sticky error
// flag. full/empty are the producer/consumer's only backpressure indicators.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic                     prediction,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     taken,
  output logic                     transition,
  output logic                     mispredict,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         mispredict_count,
  output logic                     error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  // Control view of the queue, derived purely from occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } ctrl_state_t;

  logic             r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [OCC_W-1:0] r_occ;
  logic             r_full;
  logic             r_empty;
  logic             r_taken;
  logic             r_transition;
  logic             r_mispredict;
  logic [CNT_W-1:0] r_count;
  logic             r_error;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_push_err;
  logic             w_pop_err;
  logic             w_head_entry;
  logic             w_miss;
  logic             w_flush;
  logic [PTR_W-1:0] w_head_next;
  logic [PTR_W-1:0] w_tail_next;
  logic [OCC_W-1:0] w_occ_next;
  ctrl_state_t      w_ctrl_state_next;

  // Request acceptance, mispredict detection and next queue state.
  always_comb begin
    w_pop_ok     = resolve_valid && !r_empty;
    // A pop in the same cycle frees a slot, so a push into a full queue is fine then.
    w_push_ok    = pred_valid && (!r_full || w_pop_ok);
    w_push_err   = pred_valid && !w_push_ok;
    w_pop_err    = resolve_valid && r_empty;
    w_head_entry = r_mem[r_head];
    w_miss       = w_pop_ok && (w_head_entry != resolve_taken);
`ifdef MISPREDICT_FLUSH_EN
    w_flush      = w_miss;
`else
    w_flush      = 1'b0;
`endif

    w_head_next = r_head;
    if (w_pop_ok) w_head_next = r_head + PTR_W'(1);

    w_tail_next = r_tail;
    w_occ_next  = r_occ + OCC_W'(w_push_ok) - OCC_W'(w_pop_ok);
    if (w_flush) begin
      // Everything younger than the mispredicted branch is wrong-path work.
      w_tail_next = w_head_next;
      w_occ_next  = '0;
    end else if (w_push_ok) begin
      w_tail_next = r_tail + PTR_W'(1);
    end

    if (w_occ_next == '0)
      w_ctrl_state_next = ST_EMPTY;
    else if (w_occ_next == OCC_W'(DEPTH))
      w_ctrl_state_next = ST_FULL;
    else
      w_ctrl_state_next = ST_PARTIAL;
  end

  // Prediction storage; stale slots are harmless since pointers define validity.
  always_ff @(posedge clock) begin
    if (!reset && w_push_ok) r_mem[r_tail] <= prediction;
  end

  // Pointers, occupancy, status flags and registered training outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_occ        <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_taken      <= 1'b0;
      r_transition <= 1'b0;
      r_mispredict <= 1'b0;
      r_count      <= '0;
      r_error      <= 1'b0;
    end else begin
      r_head       <= w_head_next;
      r_tail       <= w_tail_next;
      r_occ        <= w_occ_next;
      r_full       <= (w_ctrl_state_next == ST_FULL);
      r_empty      <= (w_ctrl_state_next == ST_EMPTY);
      if (w_pop_ok) r_taken <= resolve_taken;
      r_transition <= w_pop_ok;
      r_mispredict <= w_miss;
      if (w_miss && (r_count != {CNT_W{1'b1}})) r_count <= r_count + CNT_W'(1);
      if (w_push_err || w_pop_err) r_error <= 1'b1;
    end
  end

  assign taken            = r_taken;
  assign transition       = r_transition;
  assign mispredict       = r_mispredict;
  assign full             = r_full;
  assign empty            = r_empty;
  assign occupancy        = r_occ;
  assign mispredict_count = r_count;
  assign error            = r_error;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Testbench for branch_resolve_queue: a table of single-cycle vectors for
// the basic push/resolve flow, then hand-written sequences for fill/overflow,
// full-queue wrap, mispredict flush and mid-operation reset.
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int OCC_W = $clog2(DEPTH) + 1;
`ifdef MISPREDICT_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic             clock;
  logic             reset;
  logic             pred_valid;
  logic             prediction;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             taken;
  logic             transition;
  logic             mispredict;
  logic             full;
  logic             empty;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] mispredict_count;
  logic             error;

  int n_checks = 0;
  int n_errors = 0;

  logic [0:0] exp_q[$];

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .pred_valid       (pred_valid),
    .prediction       (prediction),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .taken            (taken),
    .transition       (transition),
    .mispredict       (mispredict),
    .full             (full),
    .empty            (empty),
    .occupancy        (occupancy),
    .mispredict_count (mispredict_count),
    .error            (error)
  );

  typedef struct {
    logic             pv;
    logic             p;
    logic             rv;
    logic             rt;
    logic             e_taken;
    logic             e_trans;
    logic             e_mis;
    logic [OCC_W-1:0] e_occ;
    logic             e_full;
    logic             e_empty;
    logic [CNT_W-1:0] e_cnt;
    logic             e_err;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic pv, p, rv, rt, e_taken, e_trans, e_mis,
                              input int e_occ, input logic e_full, e_empty,
                              input int e_cnt, input logic e_err);
    vec_t v;
    v.pv = pv; v.p = p; v.rv = rv; v.rt = rt;
    v.e_taken = e_taken; v.e_trans = e_trans; v.e_mis = e_mis;
    v.e_occ = OCC_W'(e_occ); v.e_full = e_full; v.e_empty = e_empty;
    v.e_cnt = CNT_W'(e_cnt); v.e_err = e_err;
    return v;
  endfunction

  // Driver tasks
  task automatic set_in(input logic pv, p, rv, rt);
    pred_valid    = pv;
    prediction    = p;
    resolve_valid = rv;
    resolve_taken = rt;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_taken, e_trans, e_mis,
                         input logic [OCC_W-1:0] e_occ, input logic e_full, e_empty,
                         input logic [CNT_W-1:0] e_cnt, input logic e_err);
    chk({tag, ".taken"},      32'(taken),            32'(e_taken));
    chk({tag, ".transition"}, 32'(transition),       32'(e_trans));
    chk({tag, ".mispredict"}, 32'(mispredict),       32'(e_mis));
    chk({tag, ".occupancy"},  32'(occupancy),        32'(e_occ));
    chk({tag, ".full"},       32'(full),             32'(e_full));
    chk({tag, ".empty"},      32'(empty),            32'(e_empty));
    chk({tag, ".count"},      32'(mispredict_count), 32'(e_cnt));
    chk({tag, ".error"},      32'(error),            32'(e_err));
  endtask

  initial begin
    logic [7:0] pat;
    logic       front;
    logic       rt;
    logic       e_mis;
    int         e_cnt;

    // Push 1,0,1, resolve 1,1,1 (second one mispredicts), then empty-queue cases.
    vecs[0]  = mk(1, 1, 0, 0,  0, 0, 0,  1, 0, 0,  0, 0);
    vecs[1]  = mk(1, 0, 0, 0,  0, 0, 0,  2, 0, 0,  0, 0);
    vecs[2]  = mk(1, 1, 0, 0,  0, 0, 0,  3, 0, 0,  0, 0);
    vecs[3]  = mk(0, 0, 1, 1,  1, 1, 0,  2, 0, 0,  0, 0);
    vecs[4]  = mk(0, 0, 1, 1,  1, 1, 1,  FLUSH ? 0 : 1, 0, FLUSH,  1, 0);
    vecs[5]  = mk(0, 0, 1, 1,  1, !FLUSH, 0,  0, 0, 1,  1, FLUSH);
    vecs[6]  = mk(0, 0, 0, 0,  1, 0, 0,  0, 0, 1,  1, FLUSH);
    vecs[7]  = mk(0, 0, 1, 0,  1, 0, 0,  0, 0, 1,  1, 1);
    vecs[8]  = mk(0, 0, 0, 0,  1, 0, 0,  0, 0, 1,  1, 1);
    vecs[9]  = mk(1, 0, 1, 1,  1, 0, 0,  1, 0, 0,  1, 1);
    vecs[10] = mk(0, 0, 1, 0,  0, 1, 0,  0, 0, 1,  1, 1);

    do_reset();
    chk_all("reset", 0, 0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      set_in(vecs[i].pv, vecs[i].p, vecs[i].rv, vecs[i].rt);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_taken, vecs[i].e_trans, vecs[i].e_mis,
              vecs[i].e_occ, vecs[i].e_full, vecs[i].e_empty, vecs[i].e_cnt, vecs[i].e_err);
    end
    set_in(0, 0, 0, 0);

    // Fill to DEPTH, overflow push, push+resolve while full, drain through the wrap.
    do_reset();
    exp_q.delete();
    e_cnt = 0;
    pat = 8'b1011_0010;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, pat[i], 0, 0);
      step();
      exp_q.push_back(pat[i]);
      chk($sformatf("fill%0d.occupancy", i), 32'(occupancy), i + 1);
    end
    chk("fill.full", 32'(full), 1);
    chk("fill.error", 32'(error), 0);
    set_in(1, 0, 0, 0);
    step();
    chk("overflow.full", 32'(full), 1);
    chk("overflow.occupancy", 32'(occupancy), DEPTH);
    chk("overflow.error", 32'(error), 1);

    front = exp_q.pop_front();
    set_in(1, 1, 1, front);
    step();
    exp_q.push_back(1'b1);
    chk("fullswap.occupancy", 32'(occupancy), DEPTH);
    chk("fullswap.full", 32'(full), 1);
    chk("fullswap.transition", 32'(transition), 1);
    chk("fullswap.mispredict", 32'(mispredict), 0);
    chk("fullswap.taken", 32'(taken), 32'(front));

    for (int i = 0; i < DEPTH; i++) begin
      front = exp_q.pop_front();
      // The final pop is the entry pushed into the wrapped slot; resolve it wrong.
      rt = (i == DEPTH - 1) ? ~front : front;
      e_mis = (rt != front);
      if (e_mis) e_cnt++;
      set_in(0, 0, 1, rt);
      step();
      chk($sformatf("drain%0d.transition", i), 32'(transition), 1);
      chk($sformatf("drain%0d.taken", i), 32'(taken), 32'(rt));
      chk($sformatf("drain%0d.mispredict", i), 32'(mispredict), 32'(e_mis));
      chk($sformatf("drain%0d.count", i), 32'(mispredict_count), e_cnt);
    end
    set_in(0, 0, 0, 0);
    chk("drain.empty", 32'(empty), 1);
    chk("drain.full", 32'(full), 0);
    chk("drain.occupancy", 32'(occupancy), 0);

    // Mispredict with a same-cycle push: flush build discards everything.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, 0);
      step();
    end
    chk("preflush.occupancy", 32'(occupancy), 4);
    set_in(1, 1, 1, 0);
    step();
    chk("flush.mispredict", 32'(mispredict), 1);
    chk("flush.occupancy", 32'(occupancy), FLUSH ? 0 : 4);
    chk("flush.empty", 32'(empty), 32'(FLUSH));
    chk("flush.count", 32'(mispredict_count), 1);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 1, 1);
      step();
      chk($sformatf("postflush%0d.transition", i), 32'(transition), FLUSH ? 0 : 1);
      chk($sformatf("postflush%0d.mispredict", i), 32'(mispredict), 0);
      chk($sformatf("postflush%0d.occupancy", i), 32'(occupancy), FLUSH ? 0 : 3 - i);
      chk($sformatf("postflush%0d.error", i), 32'(error), 32'(FLUSH));
    end
    set_in(0, 0, 0, 0);

    // Build occupancy 5 with count 3, then reset while a resolve is requested.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 0);
      step();
      set_in(0, 0, 1, 0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 0);
      step();
    end
    chk("prereset.occupancy", 32'(occupancy), 5);
    chk("prereset.count", 32'(mispredict_count), 3);
    reset = 1'b1;
    set_in(1, 1, 1, 1);
    step();
    chk_all("midreset", 0, 0, 0, 0, 0, 1, 0, 0);
    reset = 1'b0;
    set_in(0, 0, 0, 0);
    step();
    chk_all("postreset", 0, 0, 0, 0, 0, 1, 0, 0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
